// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch target, destination select, EX/MEM register.
// Define EX_MULT_EN to build the iterative signed multiplier with HI/LO and front-end stall.
module ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegDstIN,
  input  logic        BranchIN,
  input  logic        MemReadIN,
  input  logic        MemtoRegIN,
  input  logic        MemWriteIN,
  input  logic        ALUSrcIN,
  input  logic        RegWriteIN,
  input  logic [1:0]  ALUOpIN,
  input  logic [31:0] nextPcIN,
  input  logic [31:0] readData1IN,
  input  logic [31:0] readData2IN,
  input  logic [31:0] signExtIN,
  input  logic [4:0]  ins20_16IN,
  input  logic [4:0]  ins15_11IN,
  output logic        BranchOUT,
  output logic        MemReadOUT,
  output logic        MemtoRegOUT,
  output logic        MemWriteOUT,
  output logic        RegWriteOUT,
  output logic        zeroOUT,
  output logic [31:0] aluResultOUT,
  output logic [31:0] writeDataOUT,
  output logic [31:0] branchTargetOUT,
  output logic [4:0]  writeRegOUT,
  output logic        stallOUT
);

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [5:0]  funct;
  logic [31:0] alu_res;
  logic        is_mult;
  logic        is_mfx;
  logic        bubble;
  logic        kill_rw;

  assign op_a  = readData1IN;
  assign op_b  = ALUSrcIN ? signExtIN : readData2IN;
  assign funct = signExtIN[5:0];

  assign is_mult = (ALUOpIN == 2'b10) && (funct == F_MULT);
  assign is_mfx  = (ALUOpIN == 2'b10) && ((funct == F_MFHI) || (funct == F_MFLO));

`ifdef EX_MULT_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mstate_t;

  mstate_t     state;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;

  assign stallOUT = !reset && (((state == IDLE) && is_mult) || (state == BUSY));
  // MULT never writes a register, so it leaves EX as a bubble even in DONE.
  assign bubble   = stallOUT || is_mult;
  assign kill_rw  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_mag <= 32'd0;
      b_mag <= 32'd0;
      neg   <= 1'b0;
      acc   <= 64'd0;
      cnt   <= 5'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mult) begin
            a_mag <= op_a[31] ? -op_a : op_a;
            b_mag <= op_b[31] ? -op_b : op_b;
            neg   <= op_a[31] ^ op_b[31];
            acc   <= 64'd0;
            cnt   <= 5'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (b_mag[cnt])
            acc <= acc + ({32'd0, a_mag} << cnt);
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31)
            state <= DONE;
        end
        DONE: begin
          {hi, lo} <= neg ? -acc : acc;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign stallOUT = 1'b0;
  assign bubble   = 1'b0;
  // Without the multiplier these functs must not write a garbage zero into rd.
  assign kill_rw  = is_mult || is_mfx;
`endif

  always_comb begin
    alu_res = 32'd0;
    case (ALUOpIN)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b11: alu_res = op_a | op_b;
      default: begin
        case (funct)
          F_ADD:  alu_res = op_a + op_b;
          F_SUB:  alu_res = op_a - op_b;
          F_AND:  alu_res = op_a & op_b;
          F_OR:   alu_res = op_a | op_b;
          F_NOR:  alu_res = ~(op_a | op_b);
          F_SLT:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
`ifdef EX_MULT_EN
          F_MFHI: alu_res = hi;
          F_MFLO: alu_res = lo;
`endif
          default: alu_res = 32'd0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      BranchOUT       <= 1'b0;
      MemReadOUT      <= 1'b0;
      MemtoRegOUT     <= 1'b0;
      MemWriteOUT     <= 1'b0;
      RegWriteOUT     <= 1'b0;
      zeroOUT         <= 1'b0;
      aluResultOUT    <= 32'd0;
      writeDataOUT    <= 32'd0;
      branchTargetOUT <= 32'd0;
      writeRegOUT     <= 5'd0;
    end else if (bubble) begin
      BranchOUT   <= 1'b0;
      MemReadOUT  <= 1'b0;
      MemtoRegOUT <= 1'b0;
      MemWriteOUT <= 1'b0;
      RegWriteOUT <= 1'b0;
    end else begin
      BranchOUT       <= BranchIN;
      MemReadOUT      <= MemReadIN;
      MemtoRegOUT     <= MemtoRegIN;
      MemWriteOUT     <= MemWriteIN;
      RegWriteOUT     <= RegWriteIN && !kill_rw;
      zeroOUT         <= (alu_res == 32'd0);
      aluResultOUT    <= alu_res;
      writeDataOUT    <= readData2IN;
      branchTargetOUT <= nextPcIN + {signExtIN[29:0], 2'b00};
      writeRegOUT     <= RegDstIN ? ins15_11IN : ins20_16IN;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table through a scoreboard, plus multiplier sequences.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegDstIN, BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, ALUSrcIN, RegWriteIN;
  logic [1:0]  ALUOpIN;
  logic [31:0] nextPcIN, readData1IN, readData2IN, signExtIN;
  logic [4:0]  ins20_16IN, ins15_11IN;
  logic        BranchOUT, MemReadOUT, MemtoRegOUT, MemWriteOUT, RegWriteOUT, zeroOUT;
  logic [31:0] aluResultOUT, writeDataOUT, branchTargetOUT;
  logic [4:0]  writeRegOUT;
  logic        stallOUT;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset),
    .RegDstIN(RegDstIN), .BranchIN(BranchIN), .MemReadIN(MemReadIN),
    .MemtoRegIN(MemtoRegIN), .MemWriteIN(MemWriteIN), .ALUSrcIN(ALUSrcIN),
    .RegWriteIN(RegWriteIN), .ALUOpIN(ALUOpIN), .nextPcIN(nextPcIN),
    .readData1IN(readData1IN), .readData2IN(readData2IN), .signExtIN(signExtIN),
    .ins20_16IN(ins20_16IN), .ins15_11IN(ins15_11IN),
    .BranchOUT(BranchOUT), .MemReadOUT(MemReadOUT), .MemtoRegOUT(MemtoRegOUT),
    .MemWriteOUT(MemWriteOUT), .RegWriteOUT(RegWriteOUT), .zeroOUT(zeroOUT),
    .aluResultOUT(aluResultOUT), .writeDataOUT(writeDataOUT),
    .branchTargetOUT(branchTargetOUT), .writeRegOUT(writeRegOUT), .stallOUT(stallOUT)
  );

  typedef struct {
    logic [31:0] alu;
    logic        zero;
    logic [31:0] bt;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [4:0]  ctl;  // {Branch, MemRead, MemtoReg, MemWrite, RegWrite}
  } exp_t;

  typedef struct {
    logic [6:0]  c7;   // {RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
    logic [1:0]  op;
    logic [31:0] npc, a, b, imm;
    logic [4:0]  rt, rd;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[12];

  function automatic vec_t mk(input logic [6:0] c7, input logic [1:0] op,
                              input logic [31:0] npc, a, b, imm,
                              input logic [4:0] rt, rd,
                              input logic [31:0] e_alu, input logic e_zero,
                              input logic [31:0] e_bt, input logic [4:0] e_wr,
                              input logic [4:0] e_ctl);
    vec_t v;
    v.c7 = c7; v.op = op; v.npc = npc; v.a = a; v.b = b; v.imm = imm;
    v.rt = rt; v.rd = rd;
    v.e.alu = e_alu; v.e.zero = e_zero; v.e.bt = e_bt; v.e.wd = b;
    v.e.wr = e_wr; v.e.ctl = e_ctl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {RegDstIN, BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, ALUSrcIN, RegWriteIN} = v.c7;
    ALUOpIN = v.op; nextPcIN = v.npc; readData1IN = v.a; readData2IN = v.b;
    signExtIN = v.imm; ins20_16IN = v.rt; ins15_11IN = v.rd;
  endtask

  // Drive one instruction, expect it in EX/MEM after one edge.
  task automatic run_vec(input string name, input vec_t v);
    exp_t e;
    drive(v);
    sb.push_back(v.e);
    #1;
    chk({name, "_stall"}, {31'd0, stallOUT}, 32'd0);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({name, "_alu"}, aluResultOUT, e.alu);
    chk({name, "_zero"}, {31'd0, zeroOUT}, {31'd0, e.zero});
    chk({name, "_bt"}, branchTargetOUT, e.bt);
    chk({name, "_wd"}, writeDataOUT, e.wd);
    chk({name, "_wr"}, {27'd0, writeRegOUT}, {27'd0, e.wr});
    chk({name, "_ctl"}, {27'd0, BranchOUT, MemReadOUT, MemtoRegOUT, MemWriteOUT, RegWriteOUT},
        {27'd0, e.ctl});
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_alu"}, aluResultOUT, 32'd0);
    chk({name, "_bt"}, branchTargetOUT, 32'd0);
    chk({name, "_wd"}, writeDataOUT, 32'd0);
    chk({name, "_misc"}, {21'd0, writeRegOUT, zeroOUT, BranchOUT, MemReadOUT, MemtoRegOUT,
                          MemWriteOUT, RegWriteOUT}, 32'd0);
    chk({name, "_stall"}, {31'd0, stallOUT}, 32'd0);
  endtask

`ifdef EX_MULT_EN
  task automatic do_mult(input string name, input logic [31:0] a, b, e_hi, e_lo);
    int n;
    logic rw_seen;
    drive(mk(7'b1000001, 2'b10, 32'h0, a, b, 32'h18, 5'd0, 5'd3, 0, 0, 0, 0, 0));
    n = 0;
    rw_seen = 1'b0;
    #1;
    while (stallOUT && n < 100) begin
      n++;
      @(posedge clk); #1;
      rw_seen |= RegWriteOUT;
    end
    chk({name, "_stall_cycles"}, n, 33);
    chk({name, "_rw_during_stall"}, {31'd0, rw_seen}, 32'd0);
    @(posedge clk); #1;
    chk({name, "_retire_rw"}, {31'd0, RegWriteOUT}, 32'd0);
    run_vec({name, "_mflo"}, mk(7'b1000001, 2'b10, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd2,
                                e_lo, (e_lo == 32'd0), 32'h48, 5'd2, 5'b00001));
    run_vec({name, "_mfhi"}, mk(7'b1000001, 2'b10, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd4,
                                e_hi, (e_hi == 32'd0), 32'h40, 5'd4, 5'b00001));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(7'b1000001, 2'b10, 32'h0, 32'h7FFFFFFF, 32'h1, 32'h20, 5'd3, 5'd5,
                  32'h80000000, 0, 32'h80, 5'd5, 5'b00001);
    vecs[1]  = mk(7'b0100000, 2'b01, 32'h100, 32'h1234, 32'h1234, 32'hFFFFFFFE, 5'd2, 5'd8,
                  32'h0, 1, 32'hF8, 5'd2, 5'b10000);
    vecs[2]  = mk(7'b1000001, 2'b10, 32'h200, 32'hFFFFFFFF, 32'h1, 32'h2A, 5'd0, 5'd7,
                  32'h1, 0, 32'h2A8, 5'd7, 5'b00001);
    vecs[3]  = mk(7'b1000001, 2'b10, 32'h200, 32'h1, 32'hFFFFFFFF, 32'h2A, 5'd0, 5'd7,
                  32'h0, 1, 32'h2A8, 5'd7, 5'b00001);
    vecs[4]  = mk(7'b0011011, 2'b00, 32'h40, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd9, 5'd1,
                  32'hFFC, 0, 32'h30, 5'd9, 5'b01101);
    vecs[5]  = mk(7'b0000110, 2'b00, 32'h10, 32'h2000, 32'hCAFEBABE, 32'h8, 5'd4, 5'd0,
                  32'h2008, 0, 32'h30, 5'd4, 5'b00010);
    vecs[6]  = mk(7'b0000011, 2'b11, 32'h0, 32'hF0F00000, 32'h0, 32'hF0F, 5'd6, 5'd0,
                  32'hF0F00F0F, 0, 32'h3C3C, 5'd6, 5'b00001);
    vecs[7]  = mk(7'b1000001, 2'b10, 32'h0, 32'h0F0F0F0F, 32'h00FF00FF, 32'h27, 5'd0, 5'd10,
                  32'hF000F000, 0, 32'h9C, 5'd10, 5'b00001);
    vecs[8]  = mk(7'b1000001, 2'b10, 32'h0, 32'hFF00FF00, 32'h0FF00FF0, 32'h24, 5'd0, 5'd11,
                  32'h0F000F00, 0, 32'h90, 5'd11, 5'b00001);
    vecs[9]  = mk(7'b1000001, 2'b10, 32'h0, 32'h0, 32'h1, 32'h22, 5'd0, 5'd12,
                  32'hFFFFFFFF, 0, 32'h88, 5'd12, 5'b00001);
    vecs[10] = mk(7'b1000001, 2'b10, 32'h0, 32'h12340000, 32'h5678, 32'h25, 5'd0, 5'd13,
                  32'h12345678, 0, 32'h94, 5'd13, 5'b00001);
    vecs[11] = mk(7'b1000001, 2'b10, 32'h0, 32'h5, 32'h6, 32'h3F, 5'd0, 5'd14,
                  32'h0, 1, 32'hFC, 5'd14, 5'b00001);

    // Reset with nonzero inputs present.
    reset = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

`ifdef EX_MULT_EN
    do_mult("mult_m3x7", 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB);
    do_mult("mult_min", 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
    do_mult("mult_zero", 32'h0, 32'hFFFFFFF0, 32'h0, 32'h0);
    do_mult("mult_corner2", 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);

    // Abort a multiply at BUSY count 10: HI/LO must be cleared, not written.
    drive(mk(7'b1000001, 2'b10, 32'h0, 32'h5, 32'h9, 32'h18, 5'd0, 5'd3, 0, 0, 0, 0, 0));
    repeat (11) @(posedge clk);
    #1;
    chk("abort_busy_stall", {31'd0, stallOUT}, 32'd1);
    reset = 1'b1;
    drive(mk(7'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    reset = 1'b0;
    chk_zero_outputs("abort");
    run_vec("abort_mfhi", mk(7'b1000001, 2'b10, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd4,
                             32'h0, 1, 32'h40, 5'd4, 5'b00001));
    run_vec("abort_mflo", mk(7'b1000001, 2'b10, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd2,
                             32'h0, 1, 32'h48, 5'd2, 5'b00001));
`else
    run_vec("nomult_mult", mk(7'b1000001, 2'b10, 32'h0, 32'hFFFFFFFD, 32'h7, 32'h18, 5'd0, 5'd3,
                              32'h0, 1, 32'h60, 5'd3, 5'b00000));
    run_vec("nomult_mfhi", mk(7'b1000001, 2'b10, 32'h0, 32'h0, 32'h0, 32'h10, 5'd0, 5'd4,
                              32'h0, 1, 32'h40, 5'd4, 5'b00000));
    run_vec("nomult_mflo", mk(7'b1000001, 2'b10, 32'h0, 32'h0, 32'h0, 32'h12, 5'd0, 5'd2,
                              32'h0, 1, 32'h48, 5'd2, 5'b00000));
`endif

    run_vec("after_add", vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage MIPS pipeline, sitting directly downstream of the ID/EX pipeline register and upstream of the MEM stage. It consumes the decoded control bits, operands, sign-extended immediate and register specifiers latched by ID/EX. It computes the ALU result, branch target, zero flag and destination register, and latches them into the EX/MEM register it owns. An optional iterative signed multiplier with HI/LO registers stalls the front of the pipeline while it runs.

## Interface
- No parameters; datapath fixed at 32 bits, register specifiers at 5 bits.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state on a clk edge where high
- RegDstIN, BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, ALUSrcIN, RegWriteIN  in  1 each  control bits from ID/EX
- ALUOpIN  in  2  ALU operation class from ID/EX
- nextPcIN  in  32  PC+4 of the instruction in EX
- readData1IN, readData2IN, signExtIN  in  32 each  rs value, rt value, sign-extended immediate (funct = signExtIN[5:0])
- ins20_16IN, ins15_11IN  in  5 each  rt and rd specifiers
- BranchOUT, MemReadOUT, MemtoRegOUT, MemWriteOUT, RegWriteOUT  out  1 each  registered control to MEM
- zeroOUT  out  1  registered (aluResult == 0)
- aluResultOUT, writeDataOUT, branchTargetOUT  out  32 each  registered ALU result, rt value for stores, branch target
- writeRegOUT  out  5  registered destination register
- stallOUT  out  1  combinational; high = PC, IF/ID and ID/EX must hold their contents this edge

## Operation
- Operand A = readData1IN; operand B = ALUSrcIN ? signExtIN : readData2IN.
- ALU select: ALUOp 00 add (lw/sw/addi); 01 sub (beq); 11 or (ori); 10 by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed, result 1/0), 0x10 mfhi (result = HI), 0x12 mflo (result = LO), 0x18 mult. Any other funct: result 0, controls pass unchanged.
- Add/sub wrap modulo 2^32; overflow ignored, no exception.
- branchTarget = nextPcIN + (signExtIN << 2), modulo 2^32; writeReg = RegDstIN ? ins15_11IN : ins20_16IN; writeData = readData2IN.
- Without stall, every edge latches the computed values into the EX/MEM outputs.
- Multiplier FSM (signed 32x32 -> 64, shift-add on magnitudes):
  - IDLE: MULT decoded (ALUOp 10, funct 0x18) -> latch |A|, |B| and the product sign, clear accumulator and count, go to BUSY. stallOUT = 1 this cycle.
  - BUSY: one shift-add iteration per cycle, count 0..31; after count 31 go to DONE. stallOUT = 1.
  - DONE: stallOUT = 0. Edge writes {HI,LO} = sign ? -acc : acc, then returns to IDLE.
- While stallOUT = 1, EX/MEM latches a bubble: all control outputs 0, data outputs unchanged. MULT itself always retires as a bubble (RegWriteOUT = 0).

## Timing
- Reset: all outputs 0, HI = LO = 0, FSM in IDLE, stallOUT = 0. Reset during BUSY/DONE aborts the multiply; HI/LO are cleared, not written.
- ALU, branch and move latency: 1 cycle from ID/EX outputs to EX/MEM outputs.
- MULT occupies EX for 34 cycles: stallOUT high for 33 (1 IDLE + 32 BUSY), low in DONE. HI/LO are visible to an MFHI/MFLO entering EX on the cycle after DONE.
- Back-to-back MULTs: the second begins from IDLE the cycle after DONE, adding 34 more cycles. No overlap.
- Operands: latched at IDLE exit. ID/EX is held during the stall, so input changes during BUSY are ignored.
- Product corner cases: 0 x anything = 0; 0x80000000 x 0x80000000 = HI 0x40000000, LO 0x00000000.

## Configuration
- EX_MULT_EN defined: multiplier FSM, HI/LO, mfhi/mflo and stallOUT behave as above.
- EX_MULT_EN undefined: no FSM or HI/LO. stallOUT is tied 0. Funct 0x18, 0x10 and 0x12 are treated as unknown funct: result 0 and controls pass, except RegWriteOUT is forced 0 for these three.

## Test plan
- Assert reset for 2 cycles with nonzero inputs -> all outputs 0 and stallOUT 0; after release, first edge latches the inputs.
- R-type add: A = 0x7FFFFFFF, B = 1, RegDst = 1, rd = 5 -> aluResultOUT 0x80000000, writeRegOUT 5, zeroOUT 0.
- beq: ALUOp 01, A = B = 0x1234, nextPc 0x100, imm 0xFFFFFFFE -> zeroOUT 1, branchTargetOUT 0xF8, BranchOUT 1.
- slt: A = 0xFFFFFFFF, B = 1 -> result 1; swap operands -> result 0.
- With EX_MULT_EN: MULT A = -3, B = 7 -> stallOUT high exactly 33 cycles with RegWriteOUT 0 throughout. Then mflo gives 0xFFFFFFEB and mfhi gives 0xFFFFFFFF. Reset asserted at BUSY count 10 -> stallOUT 0 next cycle and mfhi returns 0.
- Without EX_MULT_EN: MULT with RegWrite 1 -> stallOUT never rises, RegWriteOUT 0 and aluResultOUT 0 one cycle later.
